// File: rtl/alu_muldiv.sv
// alu_muldiv: sequential RV32I/RV32M ALU behind a valid/ready handshake.
// Base ops and divide special cases complete in one cycle; multiply and
// divide iterate one bit per cycle and hold in_ready low while busy.
module alu_muldiv #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] inputA,
    input  logic [XLEN-1:0] inputB,
    output logic            out_valid,
    output logic [XLEN-1:0] out
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam logic [SHW-1:0]  LAST    = SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    logic              r_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out;
    logic [SHW-1:0]    r_cnt;
    logic [2*XLEN-1:0] r_acc;      // multiply: {partial high, remaining multiplier}
    logic [XLEN-1:0]   r_ma;       // multiplicand magnitude
    logic [XLEN-1:0]   r_mb;       // divisor magnitude
    logic [XLEN-1:0]   r_rem;      // divide partial remainder
    logic [XLEN-1:0]   r_quo;      // dividend shifting out, quotient shifting in
    logic              r_neg;      // product / quotient needs negation
    logic              r_rneg;     // remainder needs negation
    logic [1:0]        r_sel;      // low op bits select the result flavour

    logic              w_is_mul;
    logic              w_is_div;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN-1:0]   w_base;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_acc_nx;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_dsub;
    logic [XLEN-1:0]   w_rem_nx;
    logic [XLEN-1:0]   w_quo_nx;
    logic [XLEN-1:0]   w_quo_fin;
    logic [XLEN-1:0]   w_rem_fin;

    assign in_ready  = r_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;

    // Operand decode: signedness, magnitudes and divide special cases.
    always_comb begin
        w_is_mul = (op[4:2] == 3'b100);
        w_is_div = (op[4:2] == 3'b101);
        // mulh, mulhsu, div, rem treat A as signed; mulh, div, rem treat B as signed.
        w_a_neg  = inputA[XLEN-1] && (op == 5'd17 || op == 5'd18 || op == 5'd20 || op == 5'd22);
        w_b_neg  = inputB[XLEN-1] && (op == 5'd17 || op == 5'd20 || op == 5'd22);
        w_mag_a  = w_a_neg ? (~inputA + 1'b1) : inputA;
        w_mag_b  = w_b_neg ? (~inputB + 1'b1) : inputB;
        w_b_zero = (inputB == '0);
        w_ovf    = (op == 5'd20 || op == 5'd22) && (inputA == MOST_NEG) && (inputB == '1);
        w_fast   = w_is_div && (w_b_zero || w_ovf);
        // op[1] distinguishes rem/remu from div/divu.
        if (w_b_zero) begin
            w_fast_res = op[1] ? inputA : '1;
        end else begin
            w_fast_res = op[1] ? '0 : inputA;
        end
    end

    // Single-cycle base operations; unknown codes fall back to add.
    always_comb begin
        case (op)
            5'd1:    w_base = inputA - inputB;
            5'd2:    w_base = inputA << inputB[SHW-1:0];
            5'd3:    w_base = {{(XLEN-1){1'b0}}, ($signed(inputA) < $signed(inputB))};
            5'd4:    w_base = {{(XLEN-1){1'b0}}, (inputA < inputB)};
            5'd5:    w_base = inputA ^ inputB;
            5'd6:    w_base = inputA >> inputB[SHW-1:0];
            5'd7:    w_base = $signed(inputA) >>> inputB[SHW-1:0];
            5'd8:    w_base = inputA | inputB;
            5'd9:    w_base = inputA & inputB;
            default: w_base = inputA + inputB;
        endcase
    end

    // One shift-add multiply step and one restoring divide step, plus final sign fix-up.
    always_comb begin
        w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_ma} : '0);
        w_acc_nx  = {w_sum, r_acc[XLEN-1:1]};
        w_prod    = r_neg ? (~w_acc_nx + 1'b1) : w_acc_nx;

        w_shift   = {r_rem, r_quo[XLEN-1]};
        w_ge      = (w_shift >= {1'b0, r_mb});
        w_dsub    = w_shift[XLEN-1:0] - r_mb;
        w_rem_nx  = w_ge ? w_dsub : w_shift[XLEN-1:0];
        w_quo_nx  = {r_quo[XLEN-2:0], w_ge};
        w_quo_fin = r_neg  ? (~w_quo_nx + 1'b1) : w_quo_nx;
        w_rem_fin = r_rneg ? (~w_rem_nx + 1'b1) : w_rem_nx;
    end

    // Control FSM with registered result, valid pulse and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_neg       <= 1'b0;
            r_rneg      <= 1'b0;
            r_sel       <= 2'b00;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_is_mul) begin
                            r_state <= S_MUL;
                            r_ready <= 1'b0;
                            r_cnt   <= '0;
                            r_acc   <= {{XLEN{1'b0}}, w_mag_b};
                            r_ma    <= w_mag_a;
                            r_neg   <= w_a_neg ^ w_b_neg;
                            r_sel   <= op[1:0];
                        end else if (w_is_div && !w_fast) begin
                            r_state <= S_DIV;
                            r_ready <= 1'b0;
                            r_cnt   <= '0;
                            r_rem   <= '0;
                            r_quo   <= w_mag_a;
                            r_mb    <= w_mag_b;
                            r_neg   <= w_a_neg ^ w_b_neg;
                            r_rneg  <= w_a_neg;
                            r_sel   <= op[1:0];
                        end else begin
                            r_out       <= w_fast ? w_fast_res : w_base;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_nx;
                    if (r_cnt == LAST) begin
                        // mul keeps the low half; mulh/mulhsu/mulhu the high half.
                        r_out       <= (r_sel == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    if (r_cnt == LAST) begin
                        r_out       <= r_sel[1] ? w_rem_fin : w_quo_fin;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors for base ops, fast-path divides and
// iterative multiply/divide, plus reset-abort and operand-capture sequences.
module tb_alu_muldiv;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] inputA;
    logic [XLEN-1:0] inputB;
    logic            out_valid;
    logic [XLEN-1:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t base_v[17];
    vec_t iter_v[11];

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .inputA    (inputA),
        .inputB    (inputB),
        .out_valid (out_valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit busy_ok;
        bit quiet_ok;

        base_v[0]  = '{5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000}; // add wrap
        base_v[1]  = '{5'd7,  32'h80000000, 32'h00000004, 32'hF8000000}; // sra
        base_v[2]  = '{5'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000001}; // slt
        base_v[3]  = '{5'd4,  32'hFFFFFFFF, 32'h00000001, 32'h00000000}; // sltu
        base_v[4]  = '{5'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE}; // sub
        base_v[5]  = '{5'd2,  32'h00000001, 32'hFFFFFFFF, 32'h80000000}; // sll by 31
        base_v[6]  = '{5'd6,  32'h80000000, 32'h00000004, 32'h08000000}; // srl
        base_v[7]  = '{5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0}; // xor
        base_v[8]  = '{5'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0}; // or
        base_v[9]  = '{5'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000}; // and
        base_v[10] = '{5'd12, 32'h00000002, 32'h00000003, 32'h00000005}; // unknown -> add
        base_v[11] = '{5'd20, 32'h00000005, 32'h00000000, 32'hFFFFFFFF}; // div by 0
        base_v[12] = '{5'd23, 32'h00000005, 32'h00000000, 32'h00000005}; // remu by 0
        base_v[13] = '{5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000}; // div overflow
        base_v[14] = '{5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h00000000}; // rem overflow
        base_v[15] = '{5'd21, 32'h00000009, 32'h00000000, 32'hFFFFFFFF}; // divu by 0
        base_v[16] = '{5'd22, 32'h00000009, 32'h00000000, 32'h00000009}; // rem by 0

        iter_v[0]  = '{5'd17, 32'h80000000, 32'h80000000, 32'h40000000}; // mulh
        iter_v[1]  = '{5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}; // mulhsu
        iter_v[2]  = '{5'd16, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB}; // mul 7*-3
        iter_v[3]  = '{5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE}; // mulhu
        iter_v[4]  = '{5'd20, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD}; // div -7/2
        iter_v[5]  = '{5'd22, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF}; // rem -7%2
        iter_v[6]  = '{5'd21, 32'h00000064, 32'h00000007, 32'h0000000E}; // divu 100/7
        iter_v[7]  = '{5'd23, 32'h00000064, 32'h00000007, 32'h00000002}; // remu 100%7
        iter_v[8]  = '{5'd20, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD}; // div 7/-2
        iter_v[9]  = '{5'd22, 32'h00000007, 32'hFFFFFFFE, 32'h00000001}; // rem 7%-2
        iter_v[10] = '{5'd23, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF}; // remu large divisor

        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 5'd0;
        inputA   = '0;
        inputB   = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset out", out, 32'h0);
        chk("reset out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset in_ready", {31'b0, in_ready}, 32'h1);

        // Base ops and fast-path divides, back to back with no bubbles.
        for (int i = 0; i < 17; i++) begin
            op       = base_v[i].op;
            inputA   = base_v[i].a;
            inputB   = base_v[i].b;
            in_valid = 1'b1;
            step();
            chk($sformatf("base[%0d] out", i), out, base_v[i].exp);
            chk($sformatf("base[%0d] out_valid", i), {31'b0, out_valid}, 32'h1);
            chk($sformatf("base[%0d] in_ready", i), {31'b0, in_ready}, 32'h1);
        end
        in_valid = 1'b0;
        step();
        chk("idle out_valid low", {31'b0, out_valid}, 32'h0);
        chk("idle out holds", out, 32'h00000009);

        // Iterative ops: busy for XLEN cycles, result in the DONE cycle.
        for (int i = 0; i < 11; i++) begin
            op       = iter_v[i].op;
            inputA   = iter_v[i].a;
            inputB   = iter_v[i].b;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            busy_ok  = 1'b1;
            for (int c = 0; c < XLEN; c++) begin
                if (c != 0) step();
                if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_ok = 1'b0;
            end
            chk($sformatf("iter[%0d] busy window", i), {31'b0, busy_ok}, 32'h1);
            step();
            chk($sformatf("iter[%0d] out", i), out, iter_v[i].exp);
            chk($sformatf("iter[%0d] out_valid", i), {31'b0, out_valid}, 32'h1);
            chk($sformatf("iter[%0d] ready in DONE", i), {31'b0, in_ready}, 32'h0);
            step();
            chk($sformatf("iter[%0d] ready after", i), {31'b0, in_ready}, 32'h1);
            chk($sformatf("iter[%0d] valid pulse", i), {31'b0, out_valid}, 32'h0);
        end

        // Reset while a multiply is in flight, with a request held during reset.
        op       = 5'd16;
        inputA   = 32'h00001234;
        inputB   = 32'h00005678;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 9; c++) step();
        rst      = 1'b1;
        op       = 5'd0;
        inputA   = 32'd2;
        inputB   = 32'd3;
        in_valid = 1'b1;
        step();
        chk("abort out", out, 32'h0);
        chk("abort out_valid", {31'b0, out_valid}, 32'h0);
        chk("abort in_ready", {31'b0, in_ready}, 32'h1);
        step();
        chk("rst beats in_valid", {31'b0, out_valid}, 32'h0);
        chk("rst beats in_valid out", out, 32'h0);
        rst      = 1'b0;
        in_valid = 1'b0;
        quiet_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (out_valid !== 1'b0) quiet_ok = 1'b0;
        end
        chk("no result after abort", {31'b0, quiet_ok}, 32'h1);
        op       = 5'd0;
        inputA   = 32'd2;
        inputB   = 32'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("add after reset", out, 32'd5);
        chk("add after reset valid", {31'b0, out_valid}, 32'h1);

        // divu with operands scrambled while busy and a request held throughout.
        op       = 5'd21;
        inputA   = 32'd1000;
        inputB   = 32'd7;
        in_valid = 1'b1;
        step();
        op      = 5'd0;
        busy_ok = 1'b1;
        for (int c = 0; c < XLEN; c++) begin
            if (c != 0) step();
            if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_ok = 1'b0;
            inputA = $urandom;
            inputB = $urandom;
        end
        chk("capture busy window", {31'b0, busy_ok}, 32'h1);
        step();
        chk("capture divu out", out, 32'd142);
        chk("capture divu valid", {31'b0, out_valid}, 32'h1);
        step();
        chk("capture ready back", {31'b0, in_ready}, 32'h1);
        inputA = 32'd10;
        inputB = 32'd20;
        step();
        in_valid = 1'b0;
        chk("held request out", out, 32'd30);
        chk("held request valid", {31'b0, out_valid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, sequential successor to the single-cycle integer ALU: executes the base RV32I ALU operations plus the RV32M multiply/divide/remainder operations behind a valid/ready handshake. Base ops return a registered result one cycle after acceptance. Multiply and divide run iteratively at one bit per cycle, except divide special cases, which take the one-cycle fast path. Sits in the execute stage; the pipeline stalls on `in_ready` low.

## Interface
- `XLEN`, 32: operand/result width; power of two, ≥ 8.
- `SHW`, `$clog2(XLEN)`: shift-amount width (derived, not overridden).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit idle, can accept; request accepted on `in_valid && in_ready` at an edge.
- `op`  in  5  operation select (encoding below).
- `inputA`  in  XLEN  operand A / rs1.
- `inputB`  in  XLEN  operand B / rs2 or immediate.
- `out_valid`  out  1  one-cycle pulse: `out` holds a new result.
- `out`  out  XLEN  result; holds its value until the next result.

## Operation
- Op encoding: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 16 mul, 17 mulh, 18 mulhsu, 19 mulhu, 20 div, 21 divu, 22 rem, 23 remu. Any other code executes as add.
- Base ops: shifts use `inputB[SHW-1:0]`. sra is arithmetic. slt is signed and sltu unsigned; both produce 0 or 1, zero-extended. add/sub wrap modulo 2^XLEN.
- Operands and op are captured at acceptance; later input changes have no effect.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL on accepting mul*.
  - IDLE → DIV on accepting div*/rem* with no special case.
  - MUL/DIV → DONE after XLEN iterations.
  - DONE → IDLE after one cycle.
  - A base op or divide special case is accepted in IDLE, registered directly, and the FSM stays in IDLE.
- Multiply: operand magnitudes are taken per signedness; mulhsu treats A as signed and B as unsigned. A 2·XLEN shift-add accumulator runs one bit per cycle. The 2·XLEN product is negated at finish when the signs differ. mul returns the low XLEN bits; mulh/mulhsu/mulhu return the high XLEN bits.
- Divide: restoring divide on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
- Divide special cases (fast path, no iteration):
  - B = 0: div/divu → all ones; rem/remu → A.
  - Signed overflow (A = most-negative, B = −1): div → A; rem → 0.

## Timing
- Reset values: `out` = 0, `out_valid` = 0, `in_ready` = 1, FSM = IDLE; iteration counter and accumulators cleared.
- Base op or fast path: accepted at edge k → `out_valid` = 1 during cycle k+1. `in_ready` stays 1, so back-to-back acceptance is allowed every cycle.
- Iterative op: accepted at edge k → `in_ready` = 0 from cycle k+1 through the DONE cycle. `out_valid` = 1 during cycle k+XLEN+1 (DONE). `in_ready` returns to 1 in cycle k+XLEN+2.
- While busy, `in_valid` is ignored; the requester must hold the request.
- No output back-pressure: `out_valid` is exactly one cycle; the consumer must capture it.
- `rst` asserted mid-operation: at that edge the operation is aborted, no `out_valid` is produced, and all reset values apply in the next cycle.
- `rst` wins over a simultaneous `in_valid`; the request is not accepted.
- Iteration counter runs 0..XLEN−1 and never wraps past DONE.

## Test plan
- Reset then base ops back-to-back (XLEN=32): add 0xFFFFFFFF+1 → 0x00000000. sra 0x80000000>>4 → 0xF8000000. slt −1<1 → 1. sltu 0xFFFFFFFF<1 → 0. Each result gets `out_valid` the cycle after acceptance, with no bubbles.
- mulh 0x80000000×0x80000000 → 0x40000000; mulhsu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; mul 7×−3 → 0xFFFFFFEB. For each, `out_valid` occurs exactly 33 cycles after acceptance and `in_ready` is low in between.
- div −7/2 → 0xFFFFFFFD and rem −7%2 → 0xFFFFFFFF; divu 100/7 → 14 and remu → 2. Each completes in 33 cycles.
- Fast path: div 5/0 → 0xFFFFFFFF; remu 5%0 → 5; div 0x80000000/−1 → 0x80000000; rem → 0. Each produces `out_valid` at +1 cycle and `in_ready` never drops.
- Issue mul, pulse `rst` at cycle 10 while busy → no `out_valid`, `out` = 0, `in_ready` = 1 next cycle. A following add 2+3 → 5 at +1 cycle.
- Change `inputA`/`inputB` every cycle during a divu and hold `in_valid` high while busy → result matches the operands captured at acceptance. The held request is accepted in the cycle `in_ready` returns.
